// File: rtl/bus_store_buffer.sv
// bus_store_buffer: posted-write FIFO between the store stage and a valid/ready write bus.
// Optional tail-entry store merging when STORE_BUF_COALESCE_EN is defined.
module bus_store_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       st_valid,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    output logic                       st_ready,
    output logic [ADDR_W-1:0]          bus_addr,
    output logic [DATA_W-1:0]          bus_dout,
    output logic                       bus_write_valid,
    input  logic                       bus_write_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, tail_ptr;
    logic full, hit, push, pop, alloc;
    assign tail_ptr = wr_ptr - PW'(1);
    assign full = count == CW'(DEPTH);
`ifdef STORE_BUF_COALESCE_EN
    // Only merge when the tail is not the head currently presented on the bus.
    assign hit = (count >= CW'(2)) && (addr_mem[tail_ptr] == st_addr);
    assign st_ready = !full || hit;
`else
    assign hit = 1'b0;
    assign st_ready = !full;
`endif
    assign push = st_valid && st_ready;
    assign pop = bus_write_valid && bus_write_ready;
    assign alloc = push && !hit;
    assign bus_write_valid = count != '0;
    assign empty = count == '0;
    // Gated so a discarded head never leaks onto the bus after reset.
    assign bus_addr = bus_write_valid ? addr_mem[rd_ptr] : '0;
    assign bus_dout = bus_write_valid ? data_mem[rd_ptr] : '0;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (alloc) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (alloc && !pop) count <= count + CW'(1);
            else if (pop && !alloc) count <= count - CW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_mem[wr_ptr] <= st_addr;
            data_mem[wr_ptr] <= st_data;
        end else if (push) begin
            data_mem[tail_ptr] <= st_data;
        end
    end
endmodule

// File: tb/tb_bus_store_buffer.sv
// tb_bus_store_buffer: directed self-checking bench for bus_store_buffer.
// Define STORE_BUF_COALESCE_EN for both files to check the merging build.
module tb_bus_store_buffer;
    logic        clk = 1'b0;
    logic        reset_n, st_valid, st_ready, bus_write_valid, bus_write_ready, empty;
    logic [31:0] st_addr, st_data, bus_addr, bus_dout;
    logic [2:0]  count;
    int tests = 0;
    int fails = 0;

    bus_store_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .st_valid(st_valid), .st_addr(st_addr),
        .st_data(st_data), .st_ready(st_ready), .bus_addr(bus_addr), .bus_dout(bus_dout),
        .bus_write_valid(bus_write_valid), .bus_write_ready(bus_write_ready),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; bus_write_ready = 1'b0;
        @(negedge clk);
        step();
        step();
        reset_n = 1'b1;
        step();
        tests++;
        if ({bus_write_valid, empty, count, st_ready} !== {1'b0, 1'b1, 3'd0, 1'b1}) begin
            fails++;
            $display("FAIL reset_flags got v/e/c/r=%b/%b/%0d/%b exp 0/1/0/1", bus_write_valid, empty, count, st_ready);
        end
        tests++;
        if ({bus_addr, bus_dout} !== 64'd0) begin
            fails++;
            $display("FAIL reset_bus got addr=%h data=%h exp 0/0", bus_addr, bus_dout);
        end
    endtask

    task automatic test_fill();
        bus_write_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1; st_addr = 32'hE000_0000 + 32'(4 * i); st_data = 32'(i);
            tests++;
            if (st_ready !== 1'b1) begin
                fails++;
                $display("FAIL fill_ready[%0d] got %b exp 1", i, st_ready);
            end
            step();
        end
        st_addr = 32'hE000_0010; st_data = 32'd4;
        for (int k = 0; k < 2; k++) begin
            tests++;
            if ({count, st_ready, bus_write_valid} !== {3'd4, 1'b0, 1'b1}) begin
                fails++;
                $display("FAIL full_state[%0d] got c/r/v=%0d/%b/%b exp 4/0/1", k, count, st_ready, bus_write_valid);
            end
            tests++;
            if ({bus_addr, bus_dout} !== {32'hE000_0000, 32'd0}) begin
                fails++;
                $display("FAIL full_head[%0d] got %h/%h exp e0000000/0", k, bus_addr, bus_dout);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_count [5];
        exp_count = '{3'd4, 3'd3, 3'd3, 3'd2, 3'd1};
        bus_write_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) st_valid = 1'b0;
            tests++;
            if ({bus_write_valid, count} !== {1'b1, exp_count[k]}) begin
                fails++;
                $display("FAIL drain_count[%0d] got v/c=%b/%0d exp 1/%0d", k, bus_write_valid, count, exp_count[k]);
            end
            tests++;
            if ({bus_addr, bus_dout} !== {32'hE000_0000 + 32'(4 * k), 32'(k)}) begin
                fails++;
                $display("FAIL drain_head[%0d] got %h/%h exp %h/%h", k, bus_addr, bus_dout, 32'hE000_0000 + 32'(4 * k), k);
            end
            if (k == 1) begin
                tests++;
                if (st_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL drain_push_ready got %b exp 1", st_ready);
                end
            end
            step();
        end
        tests++;
        if ({bus_write_valid, empty, count} !== {1'b0, 1'b1, 3'd0}) begin
            fails++;
            $display("FAIL drain_empty got v/e/c=%b/%b/%0d exp 0/1/0", bus_write_valid, empty, count);
        end
    endtask

    task automatic test_latency();
        bus_write_ready = 1'b1;
        st_valid = 1'b1; st_addr = 32'h1234_5678; st_data = 32'hCAFE_F00D;
        step();
        st_valid = 1'b0;
        tests++;
        if ({bus_write_valid, count, bus_addr, bus_dout} !== {1'b1, 3'd1, 32'h1234_5678, 32'hCAFE_F00D}) begin
            fails++;
            $display("FAIL latency_t1 got v/c/a/d=%b/%0d/%h/%h exp 1/1/12345678/cafef00d", bus_write_valid, count, bus_addr, bus_dout);
        end
        step();
        tests++;
        if ({bus_write_valid, empty} !== 2'b01) begin
            fails++;
            $display("FAIL latency_t2 got v/e=%b/%b exp 0/1", bus_write_valid, empty);
        end
    endtask

    task automatic test_reset_mid_drain();
        bus_write_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st_valid = 1'b1; st_addr = 32'hA000_0000 + 32'(16 * i); st_data = 32'h55 + 32'(i);
            step();
        end
        st_valid = 1'b0;
        tests++;
        if (count !== 3'd2) begin
            fails++;
            $display("FAIL rst_mid_pre got count=%0d exp 2", count);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        tests++;
        if ({bus_write_valid, count, empty} !== {1'b0, 3'd0, 1'b1}) begin
            fails++;
            $display("FAIL rst_mid_post got v/c/e=%b/%0d/%b exp 0/0/1", bus_write_valid, count, empty);
        end
        bus_write_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            tests++;
            if (bus_write_valid !== 1'b0) begin
                fails++;
                $display("FAIL rst_mid_stale[%0d] got valid=%b addr=%h exp valid 0", k, bus_write_valid, bus_addr);
            end
        end
    endtask

    task automatic test_coalesce();
        logic [31:0] in_addr [3];
        logic [31:0] in_data [3];
`ifdef STORE_BUF_COALESCE_EN
        localparam int N = 2;
        logic [31:0] exp_addr [N] = '{32'hE000_0000, 32'hE000_0004};
        logic [31:0] exp_data [N] = '{32'd1, 32'd3};
`else
        localparam int N = 3;
        logic [31:0] exp_addr [N] = '{32'hE000_0000, 32'hE000_0004, 32'hE000_0004};
        logic [31:0] exp_data [N] = '{32'd1, 32'd2, 32'd3};
`endif
        in_addr = '{32'hE000_0000, 32'hE000_0004, 32'hE000_0004};
        in_data = '{32'd1, 32'd2, 32'd3};
        bus_write_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1; st_addr = in_addr[i]; st_data = in_data[i];
            step();
        end
        st_valid = 1'b0;
        tests++;
        if (count !== 3'(N)) begin
            fails++;
            $display("FAIL coalesce_count got %0d exp %0d", count, N);
        end
        bus_write_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            tests++;
            if ({bus_write_valid, bus_addr, bus_dout} !== {1'b1, exp_addr[k], exp_data[k]}) begin
                fails++;
                $display("FAIL coalesce_drain[%0d] got v/a/d=%b/%h/%h exp 1/%h/%h", k, bus_write_valid, bus_addr, bus_dout, exp_addr[k], exp_data[k]);
            end
            step();
        end
        tests++;
        if (empty !== 1'b1) begin
            fails++;
            $display("FAIL coalesce_empty got %b exp 1", empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_back_to_back();
        test_latency();
        test_reset_mid_drain();
        test_coalesce();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
